// File: rtl/shape_vertex_streamer_pkg.sv
// Shared definitions for the shape vertex streamer.
//   - shape codes (point, line, triangle, parallelogram)
//   - FSM state encoding
//   - vert_count(): total vertices emitted for a shape, including the
//     optional closing vertex
package shape_pkg;

  localparam logic [1:0] SHAPE_POINT = 2'd0;
  localparam logic [1:0] SHAPE_LINE  = 2'd1;
  localparam logic [1:0] SHAPE_TRI   = 2'd2;
  localparam logic [1:0] SHAPE_PARA  = 2'd3;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  // Closing vertex applies only to shapes with three or more vertices.
  function automatic logic [2:0] vert_count(input logic [1:0] shape,
                                            input logic       close_loop);
    logic [2:0] n;
    case (shape)
      SHAPE_POINT: n = 3'd1;
      SHAPE_LINE:  n = 3'd2;
      SHAPE_TRI:   n = 3'd3 + {2'b00, close_loop};
      default:     n = 3'd4 + {2'b00, close_loop};
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shape_vertex_streamer_vertex_complete.sv
// vertex_complete: combinational fourth-vertex generator for a
// parallelogram, p4 = p1 - p2 + p3. Each component wraps silently at its
// own width.
//   in:  x1,x2,x3 [X_WIDTH], y1,y2,y3 [Y_WIDTH]
//   out: x4 [X_WIDTH], y4 [Y_WIDTH]
module vertex_complete #(
  parameter int X_WIDTH = 4,
  parameter int Y_WIDTH = 3
) (
  input  logic [X_WIDTH-1:0] x1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [X_WIDTH-1:0] x3,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [Y_WIDTH-1:0] y2,
  input  logic [Y_WIDTH-1:0] y3,
  output logic [X_WIDTH-1:0] x4,
  output logic [Y_WIDTH-1:0] y4
);

  assign x4 = x1 - x2 + x3;
  assign y4 = y1 - y2 + y3;

endmodule

// File: rtl/shape_vertex_streamer.sv
// shape_vertex_streamer: accepts one shape instruction over in_valid/
// in_ready, then streams its vertices one per cycle over out_valid/
// out_ready.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid/in_ready : instruction handshake (ready only when idle)
//   in_shape, in_x*/in_y* : shape code and p1..p3
//   out_valid/out_ready : vertex handshake
//   out_x/out_y/out_idx/out_last : current vertex, its index, final flag
//   shape_count       : completed shapes, modulo 256
module shape_vertex_streamer
  import shape_pkg::*;
#(
  parameter int X_WIDTH    = 4,
  parameter int Y_WIDTH    = 3,
  parameter int CLOSE_LOOP = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_shape,
  input  logic [X_WIDTH-1:0] in_x1,
  input  logic [X_WIDTH-1:0] in_x2,
  input  logic [X_WIDTH-1:0] in_x3,
  input  logic [Y_WIDTH-1:0] in_y1,
  input  logic [Y_WIDTH-1:0] in_y2,
  input  logic [Y_WIDTH-1:0] in_y3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [X_WIDTH-1:0] out_x,
  output logic [Y_WIDTH-1:0] out_y,
  output logic [2:0]         out_idx,
  output logic               out_last,
  output logic [7:0]         shape_count
);

  localparam logic CL = (CLOSE_LOOP != 0);

  state_t                    state, nstate;
  logic [1:0]                shape_q;
  logic [3:0][X_WIDTH-1:0]   px;   // p1..p4, latched at accept
  logic [3:0][Y_WIDTH-1:0]   py;
  logic [2:0]                idx;
  logic [7:0]                cnt;
  logic [X_WIDTH-1:0]        x4;
  logic [Y_WIDTH-1:0]        y4;
  logic                      accept, take, last, close_vtx;
  logic [1:0]                vsel;

  vertex_complete #(.X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH)) u_vc (
    .x1(in_x1), .x2(in_x2), .x3(in_x3),
    .y1(in_y1), .y2(in_y2), .y3(in_y3),
    .x4(x4),    .y4(y4)
  );

  assign last      = (idx == vert_count(shape_q, CL) - 3'd1);
  // The closing vertex re-uses p1; for a triangle it sits where p4 would be.
  assign close_vtx = CL && (shape_q >= SHAPE_TRI) && last;
  assign vsel      = close_vtx ? 2'd0 : idx[1:0];
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign shape_count = cnt;

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_x     = '0;
    out_y     = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nstate = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        out_x     = px[vsel];
        out_y     = py[vsel];
        out_idx   = idx;
        out_last  = last;
        if (out_ready && last) nstate = ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shape_q <= SHAPE_POINT;
      px      <= '0;
      py      <= '0;
      idx     <= '0;
      cnt     <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        shape_q <= in_shape;
        px      <= {x4, in_x3, in_x2, in_x1};
        py      <= {y4, in_y3, in_y2, in_y1};
        idx     <= '0;
      end else if (take) begin
        if (last) cnt <= cnt + 8'd1;
        else      idx <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_shape_vertex_streamer.sv
module tb_shape_vertex_streamer;
  import shape_pkg::*;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid0 = 0, in_valid1 = 0;
  logic [1:0] in_shape = 0;
  logic [3:0] in_x1 = 0, in_x2 = 0, in_x3 = 0;
  logic [2:0] in_y1 = 0, in_y2 = 0, in_y3 = 0;
  logic       out_ready = 0;

  logic       in_ready0, out_valid0, out_last0;
  logic [3:0] out_x0;
  logic [2:0] out_y0, out_idx0;
  logic [7:0] cnt0;
  logic       in_ready1, out_valid1, out_last1;
  logic [3:0] out_x1;
  logic [2:0] out_y1, out_idx1;
  logic [7:0] cnt1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] x;
    logic [2:0] y;
    logic [2:0] idx;
    logic       last;
  } vtx_t;

  vtx_t q0[$];
  vtx_t q1[$];

  always #5 clk = ~clk;

  shape_vertex_streamer #(.X_WIDTH(4), .Y_WIDTH(3), .CLOSE_LOOP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_shape(in_shape), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3),
    .in_y1(in_y1), .in_y2(in_y2), .in_y3(in_y3),
    .out_valid(out_valid0), .out_ready(out_ready), .out_x(out_x0), .out_y(out_y0),
    .out_idx(out_idx0), .out_last(out_last0), .shape_count(cnt0)
  );

  shape_vertex_streamer #(.X_WIDTH(4), .Y_WIDTH(3), .CLOSE_LOOP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_shape(in_shape), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3),
    .in_y1(in_y1), .in_y2(in_y2), .in_y3(in_y3),
    .out_valid(out_valid1), .out_ready(out_ready), .out_x(out_x1), .out_y(out_y1),
    .out_idx(out_idx1), .out_last(out_last1), .shape_count(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers: every vertex taken must match the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready) begin
      if (q0.size() == 0) chk("dut0_unexpected_vertex", 1, 0);
      else begin
        vtx_t e;
        e = q0.pop_front();
        chk("dut0_vertex", {out_x0, out_y0, out_idx0, out_last0}, e);
      end
    end
    if (rst_n && out_valid1 && out_ready) begin
      if (q1.size() == 0) chk("dut1_unexpected_vertex", 1, 0);
      else begin
        vtx_t e;
        e = q1.pop_front();
        chk("dut1_vertex", {out_x1, out_y1, out_idx1, out_last1}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference vertex list for a shape, built from the instruction fields.
  task automatic push_model(input int which, input logic close);
    logic [3:0] xs[4];
    logic [2:0] ys[4];
    int n, tot;
    vtx_t v;
    xs[0] = in_x1; xs[1] = in_x2; xs[2] = in_x3; xs[3] = 4'(in_x1 - in_x2 + in_x3);
    ys[0] = in_y1; ys[1] = in_y2; ys[2] = in_y3; ys[3] = 3'(in_y1 - in_y2 + in_y3);
    n   = int'(in_shape) + 1;
    tot = (close && n >= 3) ? n + 1 : n;
    for (int i = 0; i < tot; i++) begin
      v.x    = (i < n) ? xs[i] : xs[0];
      v.y    = (i < n) ? ys[i] : ys[0];
      v.idx  = 3'(i);
      v.last = (i == tot - 1);
      if (which == 0) q0.push_back(v); else q1.push_back(v);
    end
  endtask

  task automatic send(input int which, input logic [1:0] s,
                      input logic [3:0] x1, input logic [2:0] y1,
                      input logic [3:0] x2, input logic [2:0] y2,
                      input logic [3:0] x3, input logic [2:0] y3);
    int k;
    logic rdy;
    in_shape = s; in_x1 = x1; in_y1 = y1; in_x2 = x2; in_y2 = y2; in_x3 = x3; in_y3 = y3;
    push_model(which, which == 1);
    if (which == 0) in_valid0 = 1; else in_valid1 = 1;
    k = 0;
    @(negedge clk);
    rdy = (which == 0) ? in_ready0 : in_ready1;
    while (!rdy && k < 50) begin
      @(negedge clk); k++;
      rdy = (which == 0) ? in_ready0 : in_ready1;
    end
    if (!rdy) chk("accept_timeout", 0, 1);
    tick();
    in_valid0 = 0; in_valid1 = 0;
    // Scramble inputs: the latched shape must not notice.
    in_x1 = 4'hA; in_x2 = 4'h5; in_x3 = 4'hC; in_y1 = 3'd2; in_y2 = 3'd5; in_y3 = 3'd7;
  endtask

  task automatic drain();
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 50) begin
      tick(); k++;
    end
    if (q0.size() != 0 || q1.size() != 0) chk("drain_timeout", 0, 1);
    tick();
  endtask

  logic [4:0] bp_rdy;
  initial begin
    // Reset then idle
    tick(); tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_xy", {out_x0, out_y0}, 0);
    chk("rst_idx_last", {out_idx0, out_last0}, 0);
    chk("rst_count", cnt0, 0);
    rst_n = 1;
    tick();
    @(negedge clk);
    chk("in_ready_after_reset", in_ready0, 1);
    chk("idle_out_valid", out_valid0, 0);
    tick();

    // Triangle, CLOSE_LOOP=0, with first-vertex latency check
    out_ready = 1;
    send(0, SHAPE_TRI, 4'd1, 3'd1, 4'd5, 3'd2, 4'd3, 3'd6);
    @(negedge clk);
    chk("latency_valid", out_valid0, 1);
    chk("latency_idx", out_idx0, 0);
    chk("emit_in_ready", in_ready0, 0);
    drain();
    chk("count_after_tri", cnt0, 1);

    // Parallelogram with wrapping p4 = (0,0)
    send(0, SHAPE_PARA, 4'd15, 3'd7, 4'd1, 3'd0, 4'd2, 3'd1);
    drain();
    chk("count_after_para", cnt0, 2);

    // Back-pressure on a line: vertex 0 for 3 cycles, vertex 1 for 2
    out_ready = 0;
    send(0, SHAPE_LINE, 4'd2, 3'd3, 4'd9, 3'd4, 4'd0, 3'd0);
    bp_rdy = 5'b10100;  // applied LSB first: 0,0,1,0,1
    for (int i = 0; i < 5; i++) begin
      out_ready = bp_rdy[i];
      @(negedge clk);
      chk("bp_valid", out_valid0, 1);
      chk("bp_idx", out_idx0, (i < 3) ? 0 : 1);
      chk("bp_x", out_x0, (i < 3) ? 2 : 9);
      chk("bp_in_ready", in_ready0, 0);
      tick();
    end
    out_ready = 0;
    @(negedge clk);
    chk("bp_in_ready_after", in_ready0, 1);
    chk("bp_valid_after", out_valid0, 0);
    chk("bp_queue_empty", q0.size(), 0);
    chk("count_after_line", cnt0, 3);
    out_ready = 1;
    tick();

    // Closing-loop triangle
    send(1, SHAPE_TRI, 4'd1, 3'd1, 4'd5, 3'd2, 4'd3, 3'd6);
    drain();
    chk("dut1_count", cnt1, 1);

    // Reset mid-parallelogram after vertex 1 is taken
    send(0, SHAPE_PARA, 4'd3, 3'd1, 4'd7, 3'd2, 4'd6, 3'd5);
    tick();              // vertex 0 taken
    out_ready = 0;       // vertex 1 is taken at the next edge below
    out_ready = 1;
    tick();              // vertex 1 taken
    out_ready = 0;
    rst_n = 0;
    @(negedge clk);
    chk("pre_reset_idx", out_idx0, 2);
    tick();
    @(negedge clk);
    chk("abort_out_valid", out_valid0, 0);
    chk("abort_count", cnt0, 0);
    q0.delete();
    rst_n = 1;
    tick();
    out_ready = 1;
    send(0, SHAPE_POINT, 4'd4, 3'd4, 4'd0, 3'd0, 4'd0, 3'd0);
    drain();
    chk("count_after_point", cnt0, 1);
    chk("idle_final", out_valid0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shape_vertex_streamer.md
# shape_vertex_streamer

Parametrised successor to the shape instruction processor. It accepts one decoded shape instruction (shape code plus up to three coordinates) over a valid/ready handshake. It then streams the shape's vertices, one per cycle, over a second valid/ready handshake to the rasteriser stage. It adds a line shape, computes the fourth parallelogram vertex, and offers an optional closing vertex for outline drawing.

## Interface
- `X_WIDTH`, default 4: width of every x coordinate.
- `Y_WIDTH`, default 3: width of every y coordinate.
- `CLOSE_LOOP`, default 0: when 1, shapes with 3 or more vertices re-emit p1 as a final closing vertex.
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: instruction present.
- `in_ready`, out, 1: block can accept an instruction.
- `in_shape`, in, 2: shape code. 0 = point, 1 = line, 2 = triangle, 3 = parallelogram.
- `in_x1`, `in_x2`, `in_x3`, in, X_WIDTH: vertex x coordinates p1..p3.
- `in_y1`, `in_y2`, `in_y3`, in, Y_WIDTH: vertex y coordinates p1..p3.
- `out_valid`, out, 1: vertex present.
- `out_ready`, in, 1: consumer takes the vertex.
- `out_x`, out, X_WIDTH: vertex x.
- `out_y`, out, Y_WIDTH: vertex y.
- `out_idx`, out, 3: vertex index within the shape, starting at 0.
- `out_last`, out, 1: this is the final vertex of the shape.
- `shape_count`, out, 8: number of completed shapes, wraps modulo 256.

## Operation
- Vertex counts:
  - point: 1 (p1).
  - line: 2 (p1, p2).
  - triangle: 3 (p1, p2, p3).
  - parallelogram: 4 (p1, p2, p3, p4).
  - With CLOSE_LOOP=1, triangle emits 4 vertices and parallelogram 5; the extra vertex is p1. Point and line are unaffected.
- p4 = (x1 − x2 + x3, y1 − y2 + y3), each component computed modulo 2^X_WIDTH or 2^Y_WIDTH. Wrap-around is silent and is not an error.
- Unused coordinates are ignored: p2/p3 for point, p3 for line.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid` && `in_ready`, latch shape and coordinates, register p4, set idx=0, go to EMIT.
  - EMIT: `out_valid`=1; drive the vertex selected by idx.
  - On `out_valid` && `out_ready` with `out_last`=0: idx increments.
  - On `out_valid` && `out_ready` with `out_last`=1: `shape_count` increments and the FSM returns to IDLE.
- `in_ready`=0 throughout EMIT. No instruction is accepted while a shape is streaming.
- Output stability: while `out_valid`=1 and `out_ready`=0, `out_x`, `out_y`, `out_idx` and `out_last` hold constant.
- `in_*` coordinate changes after the accept cycle have no effect on the current shape.

## Timing
- Reset (`rst_n`=0 at a clk edge) sets:
  - state = IDLE.
  - `out_valid`=0, `out_x`=0, `out_y`=0, `out_idx`=0, `out_last`=0.
  - `shape_count`=0.
  - `in_ready` is 1 from the first cycle after reset deasserts.
- Latency: an instruction accepted at edge T presents vertex 0 with `out_valid`=1 after edge T, i.e. in cycle T+1.
- Throughput: with `out_ready` held high, an N-vertex shape occupies N+1 cycles (1 accept + N emit). The next accept happens in the cycle after the last vertex is taken.
- Reset mid-shape aborts the shape:
  - no further vertices are emitted.
  - `shape_count` is cleared.
  - the latched instruction is discarded.
- `out_ready` high during IDLE is harmless.
- `in_valid` high during EMIT is ignored; the instruction is held off by `in_ready`=0.

## Structure
- Package `shape_pkg` holds:
  - the shape code constants: SHAPE_POINT=0, SHAPE_LINE=1, SHAPE_TRI=2, SHAPE_PARA=3.
  - the FSM state encoding.
  - a function `vert_count(shape, close_loop)` returning the total vertex count for a shape.
- One sub-module, `vertex_complete`: a combinational p4 generator parametrised by X_WIDTH/Y_WIDTH, with its output registered in the streamer at accept.
- The top level holds the FSM, the coordinate registers, the idx counter, the output mux and `shape_count`.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, release.
  - All outputs are 0; `in_ready`=1 in the first cycle after release.
- Triangle with CLOSE_LOOP=0: (1,1) (5,2) (3,6), `out_ready`=1.
  - Three vertices in consecutive cycles starting T+1, with idx 0..2.
  - `out_last` only on idx 2; `shape_count`=1.
- Parallelogram wrap: p1=(15,7), p2=(1,0), p3=(2,1), X=4, Y=3.
  - p4 = (0,0), i.e. 16 mod 16 and 8 mod 8; 4 vertices emitted.
- Back-pressure: line (2,3) to (9,4) with `out_ready` toggled 0,0,1,0,1.
  - Vertex 0 holds for 3 cycles, vertex 1 holds for 2 cycles.
  - `in_ready`=0 until the cycle after vertex 1 is taken.
- CLOSE_LOOP=1 triangle: (1,1) (5,2) (3,6).
  - Emits (1,1) (5,2) (3,6) (1,1), with `out_last` on idx 3.
- Reset during EMIT after vertex 1 of a parallelogram:
  - `out_valid`=0 the next cycle and `shape_count`=0.
  - A following point (4,4) streams a single vertex with idx 0 and `out_last`=1.
